// File: rtl/muldiv_seq_pkg.sv
// Shared constants for the multi-cycle multiply/divide sequencer:
// funct codes, ALU operation codes and FSM state encodings.
package muldiv_seq_pkg;

   localparam logic [5:0] FUNCT_MULT  = 6'b011000;
   localparam logic [5:0] FUNCT_MULTU = 6'b011001;
   localparam logic [5:0] FUNCT_DIV   = 6'b011010;
   localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

   localparam logic [5:0] ALU_ADDU = 6'b100001;
   localparam logic [5:0] ALU_SUBU = 6'b100011;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_NEG_A  = 3'd1;
   localparam logic [2:0] S_NEG_B  = 3'd2;
   localparam logic [2:0] S_ITER   = 3'd3;
   localparam logic [2:0] S_NEG_LO = 3'd4;
   localparam logic [2:0] S_NEG_HI = 3'd5;
   localparam logic [2:0] S_FIN    = 3'd6;

   // The four mul/div functs share the 0110xx prefix; bit 1 = divide, bit 0 = unsigned.
   function automatic logic funct_valid(input logic [5:0] f);
      return f[5:2] == 4'b0110;
   endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer that borrows the shared ALU for every add/subtract.
// Optional macro MULDIV_DZ_FLAG_EN adds a sticky div_zero output.
module muldiv_seq #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [5:0]      funct,
   input  logic [XLEN-1:0] rs_val,
   input  logic [XLEN-1:0] rt_val,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo,
   output logic [5:0]      alu_con,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   input  logic [XLEN-1:0] alu_res
`ifdef MULDIV_DZ_FLAG_EN
   ,
   output logic            div_zero
`endif
);
   import muldiv_seq_pkg::*;

   logic [2:0]      state;
   logic [CNT_W-1:0] cnt;
   logic [XLEN-1:0] opa;
   logic [XLEN-1:0] opb;
   logic            sign_a;
   logic            sign_b;
   logic            is_div;
   logic            is_signed;
   logic            lo_zero;

   logic [XLEN-1:0] sh;
   logic            msb;
   logic            carry;
   logic            div_ge;
   logic            signs_differ;
   logic            accept;
   logic            last_iter;

   assign sh           = {hi[XLEN-2:0], lo[XLEN-1]};
   assign msb          = hi[XLEN-1];
   assign carry        = alu_res < hi;
   assign div_ge       = msb | (sh >= opb);
   assign signs_differ = sign_a ^ sign_b;
   assign accept       = (state == S_IDLE) && start && funct_valid(funct);
   assign last_iter    = cnt == CNT_W'(XLEN-1);

   assign busy = (state != S_IDLE) && (state != S_FIN);
   assign done = state == S_FIN;

   // ALU request is a pure function of state; idle states park it on ADDU 0+0.
   always_comb begin
      alu_con = ALU_ADDU;
      alu_a   = '0;
      alu_b   = '0;
      case (state)
         S_NEG_A: begin
            alu_con = ALU_SUBU;
            alu_b   = opa;
         end
         S_NEG_B: begin
            alu_con = ALU_SUBU;
            alu_b   = opb;
         end
         S_ITER: begin
            if (is_div) begin
               alu_con = ALU_SUBU;
               alu_a   = sh;
               alu_b   = opb;
            end else begin
               alu_a = hi;
               alu_b = opa;
            end
         end
         S_NEG_LO: begin
            alu_con = ALU_SUBU;
            alu_b   = lo;
         end
         S_NEG_HI: begin
            if (is_div) begin
               alu_con = ALU_SUBU;
               alu_b   = hi;
            end else begin
               alu_a = ~hi;
               alu_b = {{(XLEN-1){1'b0}}, lo_zero};
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         opa       <= '0;
         opb       <= '0;
         sign_a    <= 1'b0;
         sign_b    <= 1'b0;
         is_div    <= 1'b0;
         is_signed <= 1'b0;
         lo_zero   <= 1'b0;
         hi        <= '0;
         lo        <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  is_div    <= funct[1];
                  is_signed <= ~funct[0];
                  sign_a    <= rs_val[XLEN-1];
                  sign_b    <= rt_val[XLEN-1];
                  opa       <= rs_val;
                  opb       <= rt_val;
                  cnt       <= '0;
                  if (funct[1] && (rt_val == '0)) begin
                     hi    <= rs_val;
                     lo    <= '1;
                     state <= S_FIN;
                  end else begin
                     hi    <= '0;
                     lo    <= funct[1] ? rs_val : rt_val;
                     state <= funct[0] ? S_ITER : S_NEG_A;
                  end
               end
            end
            S_NEG_A: begin
               if (sign_a) opa <= alu_res;
               state <= S_NEG_B;
            end
            S_NEG_B: begin
               // Reload lo here so the working register starts from the magnitudes.
               if (sign_b) opb <= alu_res;
               if (is_div) lo <= opa;
               else        lo <= sign_b ? alu_res : opb;
               state <= S_ITER;
            end
            S_ITER: begin
               if (is_div) begin
                  if (div_ge) begin
                     hi <= alu_res;
                     lo <= {lo[XLEN-2:0], 1'b1};
                  end else begin
                     hi <= sh;
                     lo <= {lo[XLEN-2:0], 1'b0};
                  end
               end else if (lo[0]) begin
                  hi <= {carry, alu_res[XLEN-1:1]};
                  lo <= {alu_res[0], lo[XLEN-1:1]};
               end else begin
                  hi <= {1'b0, hi[XLEN-1:1]};
                  lo <= {hi[0], lo[XLEN-1:1]};
               end
               if (last_iter) begin
                  cnt   <= '0;
                  state <= is_signed ? S_NEG_LO : S_FIN;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_NEG_LO: begin
               lo_zero <= lo == '0;
               if (signs_differ) lo <= alu_res;
               state <= S_NEG_HI;
            end
            S_NEG_HI: begin
               // Product high word takes the borrow from the low word; remainder follows the dividend.
               if (is_div ? sign_a : signs_differ) hi <= alu_res;
               state <= S_FIN;
            end
            S_FIN: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef MULDIV_DZ_FLAG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_zero <= 1'b0;
      end else if (accept) begin
         div_zero <= funct[1] && (rt_val == '0);
      end
   end
`endif

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized self-checking bench for muldiv_seq against a 64-bit arithmetic reference model.
// Also models the shared ALU that the sequencer drives.
module tb_muldiv_seq;

   localparam logic [5:0] T_MULT  = 6'b011000;
   localparam logic [5:0] T_MULTU = 6'b011001;
   localparam logic [5:0] T_DIV   = 6'b011010;
   localparam logic [5:0] T_DIVU  = 6'b011011;
   localparam logic [5:0] T_ADDU  = 6'b100001;
   localparam logic [5:0] T_SUBU  = 6'b100011;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [5:0]  funct = '0;
   logic [31:0] rs_val = '0;
   logic [31:0] rt_val = '0;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [5:0]  alu_con;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_res;
`ifdef MULDIV_DZ_FLAG_EN
   logic        div_zero;
`endif

   int checks = 0;
   int errors = 0;
   int busy_err;
   logic [5:0] con_log [0:127];

   always #5 clk = ~clk;

   always_comb begin
      alu_res = '0;
      if (alu_con == T_ADDU)      alu_res = alu_a + alu_b;
      else if (alu_con == T_SUBU) alu_res = alu_a - alu_b;
   end

   muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .funct(funct),
      .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .done(done),
      .hi(hi), .lo(lo), .alu_con(alu_con), .alu_a(alu_a), .alu_b(alu_b),
      .alu_res(alu_res)
`ifdef MULDIV_DZ_FLAG_EN
      , .div_zero(div_zero)
`endif
   );

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: {hi, lo} from plain 64-bit arithmetic.
   function automatic logic [63:0] refResult(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      p = '0;
      case (f)
         T_MULTU: p = {32'b0, a} * {32'b0, b};
         T_MULT: begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            p  = sa * sb;
         end
         T_DIVU: p = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
         default: begin
            if (b == 0) begin
               p = {a, 32'hFFFFFFFF};
            end else begin
               sa = longint'($signed(a));
               sb = longint'($signed(b));
               q  = sa / sb;
               r  = sa % sb;
               p  = {r[31:0], q[31:0]};
            end
         end
      endcase
      return p;
   endfunction

   function automatic int refLatency(input logic [5:0] f, input logic [31:0] b);
      if (f[1] && b == 0) return 1;
      return f[0] ? 33 : 37;
   endfunction

   // Drives one request and returns the cycle (edge 0 = accept) in which done appeared, 0 if never.
   task automatic applyStimulus(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                input int pulse_at, output int lat);
      @(posedge clk);
      @(negedge clk);
      start = 1'b1; funct = f; rs_val = a; rt_val = b;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      busy_err = 0;
      for (int c = 1; c <= 100; c++) begin
         if (c == pulse_at) begin
            start = 1'b1; funct = T_MULTU; rs_val = ~a; rt_val = 32'h5;
         end else begin
            start = 1'b0;
         end
         con_log[c] = alu_con;
         if (done) begin
            lat = c;
            if (busy) busy_err++;
            break;
         end
         if (!busy) busy_err++;
         @(posedge clk); #1;
      end
      start = 1'b0;
   endtask

   task automatic runOp(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int pulse_at);
      int lat;
      logic [63:0] exp;
      exp = refResult(f, a, b);
      applyStimulus(f, a, b, pulse_at, lat);
      checkOutput({tag, " latency"}, 64'(lat), 64'(refLatency(f, b)));
      checkOutput({tag, " busy"}, 64'(busy_err), 64'd0);
      checkOutput({tag, " hi"}, {32'b0, hi}, {32'b0, exp[63:32]});
      checkOutput({tag, " lo"}, {32'b0, lo}, {32'b0, exp[31:0]});
   endtask

   initial begin
      logic [5:0]  f;
      logic [31:0] a, b;
      logic [31:0] specials [0:5];
      specials[0] = 32'h80000000; specials[1] = 32'hFFFFFFFF; specials[2] = 32'h7FFFFFFF;
      specials[3] = 32'h00000001; specials[4] = 32'h00000000; specials[5] = 32'h00000002;

      #3;
      checkOutput("reset busy", 64'(busy), 64'd0);
      checkOutput("reset done", 64'(done), 64'd0);
      checkOutput("reset hi", 64'(hi), 64'd0);
      checkOutput("reset lo", 64'(lo), 64'd0);
      checkOutput("reset alu_con", 64'(alu_con), 64'(T_ADDU));
      checkOutput("reset alu_a", 64'(alu_a), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      runOp("multu max", T_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
      @(posedge clk); #1;
      checkOutput("done pulse width", 64'(done), 64'd0);

      runOp("mult -3*7", T_MULT, 32'hFFFFFFFD, 32'd7, 0);
      checkOutput("neg_a alu_con", 64'(con_log[1]), 64'(T_SUBU));
      checkOutput("neg_b alu_con", 64'(con_log[2]), 64'(T_SUBU));
      checkOutput("neg_lo alu_con", 64'(con_log[35]), 64'(T_SUBU));
      checkOutput("fin alu_con", 64'(con_log[37]), 64'(T_ADDU));

      runOp("div -7/2", T_DIV, 32'hFFFFFFF9, 32'd2, 0);

      runOp("divu 100/7", T_DIVU, 32'd100, 32'd7, 10);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("hold hi", 64'(hi), 64'd2);
      checkOutput("hold lo", 64'(lo), 64'd14);
      checkOutput("idle after fin", 64'(busy), 64'd0);

      runOp("div by zero", T_DIV, 32'h1234, 32'd0, 0);
`ifdef MULDIV_DZ_FLAG_EN
      checkOutput("div_zero set", 64'(div_zero), 64'd1);
`endif

      runOp("mult min*min", T_MULT, 32'h80000000, 32'h80000000, 0);
`ifdef MULDIV_DZ_FLAG_EN
      checkOutput("div_zero cleared", 64'(div_zero), 64'd0);
`endif
      runOp("div min/-1", T_DIV, 32'h80000000, 32'hFFFFFFFF, 0);

      @(posedge clk);
      @(negedge clk);
      start = 1'b1; funct = 6'b100000; rs_val = 32'd5; rt_val = 32'd6;
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput("invalid funct busy", 64'(busy), 64'd0);
      checkOutput("invalid funct hi kept", 64'(hi), 64'd0);

      @(negedge clk);
      start = 1'b1; funct = T_MULTU; rs_val = 32'hDEADBEEF; rt_val = 32'hCAFEF00D;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("abort busy", 64'(busy), 64'd0);
      checkOutput("abort hi", 64'(hi), 64'd0);
      checkOutput("abort lo", 64'(lo), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      runOp("divu 9/3 after reset", T_DIVU, 32'd9, 32'd3, 0);

      for (int i = 0; i < 24; i++) begin
         f = {4'b0110, 2'($urandom_range(0, 3))};
         a = ($urandom_range(0, 4) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1:       b = specials[$urandom_range(0, 5)];
            2:       b = 32'($urandom_range(1, 100));
            default: b = $urandom;
         endcase
         runOp($sformatf("random %0d f=%0h", i, f), f, a, b, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer that executes MULT/MULTU/DIV/DIVU for the MIPS core and writes the HI/LO result registers.
- It performs no 32-bit add/subtract itself; each cycle it drives the shared combinational ALU (ALUCon/A/B → ALUOut) with ADDU or SUBU and consumes the result in the same cycle.
- It sits beside the EX stage. It owns the ALU only while busy; the pipeline stalls on busy.

Parameters:
- XLEN, 32, operand/ALU width.
- CNT_W, 6, iteration counter width; must hold XLEN.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- funct  in  6  operation: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011. Other values are ignored and start is dropped.
- rs_val  in  XLEN  multiplicand / dividend.
- rt_val  in  XLEN  multiplier / divisor.
- busy  out  1  high from the cycle after accept through the last working state.
- done  out  1  one-cycle pulse in FIN.
- hi  out  XLEN  HI register: product[63:32] or remainder.
- lo  out  XLEN  LO register: product[31:0] or quotient.
- alu_con  out  6  to ALU ALUCon.
- alu_a  out  XLEN  to ALU A.
- alu_b  out  XLEN  to ALU B.
- alu_res  in  XLEN  from ALU ALUOut, combinational same cycle.

Behaviour:
- Reset: asynchronous, active-low. State=IDLE, busy=0, done=0, hi=lo=0, counter=0, internal operand regs=0. Reset mid-operation aborts with no partial write.
- ALU outputs when unused (IDLE, FIN): alu_con=100001 (ADDU), alu_a=alu_b=0. They are decoded combinationally from state.
- States: IDLE, NEG_A, NEG_B, ITER, NEG_LO, NEG_HI, FIN.
- Accept: IDLE with start=1 and a valid funct.
  - Unsigned ops go to ITER.
  - Signed ops go to NEG_A.
  - DIV/DIVU with rt_val==0 goes straight to FIN with hi=rs_val, lo=32'hFFFFFFFF.
- Signed ops always visit NEG_A/NEG_B/NEG_LO/NEG_HI, so latency is fixed. Each state writes its ALU result only if that negation is required.
  - NEG_A: SUBU 0−rs, written if rs<0.
  - NEG_B: SUBU 0−rt, written if rt<0.
- ITER runs exactly XLEN cycles; counter goes 0..XLEN−1, then exits.
- Multiply: init hi=0, lo=multiplier.
  - If lo[0]=1: ALU ADDU hi+mcand. Carry = (alu_res < hi), unsigned compare done locally. Update {hi,lo} = {carry, alu_res, lo[31:1]}.
  - Otherwise: {hi,lo} = {1'b0, hi, lo[31:1]}.
- Divide (restoring): init hi=0, lo=dividend.
  - sh = {hi[30:0], lo[31]}; msb = hi[31]. ALU SUBU sh−divisor.
  - If msb=1 or sh ≥ divisor (unsigned): hi=alu_res, lo={lo[30:0],1}.
  - Otherwise: hi=sh, lo={lo[30:0],0}.
- NEG_LO / NEG_HI:
  - MULT with sign(rs)≠sign(rt): 64-bit negate. NEG_LO: SUBU 0−lo. NEG_HI: ADDU ~hi + (lo_before==0).
  - DIV: lo negated if signs differ; hi negated if rs<0. Both are independent 32-bit SUBU 0−x.
- Latency, with start accepted at edge 0 and done in cycle N:
  - unsigned N=33.
  - signed N=37.
  - divide-by-zero N=1.
- FIN: done=1, busy=0, then IDLE. hi/lo hold until the next accepted start.
- start while not in IDLE (including FIN) is ignored; the requester must hold it.
- MULT 0x80000000×0x80000000 and DIV 0x80000000/−1 follow the same arithmetic without special-casing. The latter gives lo=0x80000000, hi=0.

Optional Feature:
- Macro MULDIV_DZ_FLAG_EN.
- Defined: adds output div_zero (1 bit). It is set with the FIN pulse of a divide-by-zero, held until the next accepted start, and cleared by reset.
- Undefined: no port; divide-by-zero result is as above, with no indication.

Decomposition:
- Shared constants include: funct codes (MULT/MULTU/DIV/DIVU), ALU codes ADDU=100001 and SUBU=100011, state encodings (3 bits).
- Single module; no sub-module. Carry and compare logic is a few local assigns.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF → done in cycle 33, hi=0xFFFFFFFE, lo=0x00000001, busy high cycles 1–32.
- MULT rs=−3, rt=7 → done cycle 37, hi=0xFFFFFFFF, lo=0xFFFFFFEB; alu_con=SUBU in NEG_A, NEG_B, NEG_LO.
- DIV rs=−7, rt=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1), done cycle 37.
- DIVU rs=100, rt=7 → lo=14, hi=2, done cycle 33; start pulsed at cycle 10 is ignored, and hi/lo are unchanged after FIN.
- DIV rs=0x1234, rt=0 → done cycle 1, hi=0x1234, lo=0xFFFFFFFF; div_zero=1 with MULDIV_DZ_FLAG_EN.
- MULTU started, rst_n low in cycle 10 → busy=0, hi=lo=0 immediately; DIVU 9/3 after release gives lo=3, hi=0.
